// File: rtl/roi_perf_monitor.sv
// Region-of-interest performance monitor: counts cycles and retired instructions
// between a start PC and an end PC, with saturation and a watchdog.
module roi_perf_monitor #(
  parameter logic [31:0] START_PC = 32'h00000170,
  parameter logic [31:0] END_PC   = 32'h00000264,
  parameter int          CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 2000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      retire_cnt_i,
  output logic [1:0]       state_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] roi_cycles_o,
  output logic [CNT_W-1:0] roi_retired_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      WD_LIM  = TIMEOUT;

  state_t      state;
  logic [31:0] prev_ret;
  logic [31:0] wd;
  logic [31:0] wd_next;
  logic        wd_hit;
  logic [CNT_W:0] cyc_sum;
  logic [CNT_W:0] ret_sum;

  // Returns {overflow, clamped sum}; the MSB flags that the sum was pinned.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] acc,
                                             input logic [31:0] inc);
    logic [32:0] sum;
    sum = 33'(acc) + 33'(inc);
    if (sum > 33'(CNT_MAX)) return {1'b1, CNT_MAX};
    else                    return {1'b0, sum[CNT_W-1:0]};
  endfunction

  // Modular subtraction absorbs wraps of the free-running retire count.
  always_comb begin
    wd_next = wd + 32'd1;
    wd_hit  = (WD_LIM != 32'd0) && (wd_next == WD_LIM);
    cyc_sum = sat_add(roi_cycles_o, 32'd1);
    ret_sum = sat_add(roi_retired_o, retire_cnt_i - prev_ret);
  end

  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      ovf_o         <= 1'b0;
      roi_cycles_o  <= '0;
      roi_retired_o <= '0;
      prev_ret      <= '0;
      wd            <= '0;
    end else if (arm_i) begin
      state         <= ARMED;
      busy_o        <= 1'b1;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
      ovf_o         <= 1'b0;
      roi_cycles_o  <= '0;
      roi_retired_o <= '0;
      wd            <= '0;
    end else begin
      case (state)
        ARMED: begin
          wd <= wd_next;
          if (wd_hit) begin
            state     <= DONE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end else if (pc_i == START_PC) begin
            state    <= ACTIVE;
            prev_ret <= retire_cnt_i;
          end
        end
        ACTIVE: begin
          wd            <= wd_next;
          roi_cycles_o  <= cyc_sum[CNT_W-1:0];
          roi_retired_o <= ret_sum[CNT_W-1:0];
          ovf_o         <= ovf_o | cyc_sum[CNT_W] | ret_sum[CNT_W];
          prev_ret      <= retire_cnt_i;
          // END takes precedence over a watchdog expiry on the same edge.
          if (pc_i == END_PC) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (wd_hit) begin
            state     <= DONE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_roi_perf_monitor.sv
// Directed bench for roi_perf_monitor: three instances cover default widths,
// a short watchdog, and an 8-bit saturating configuration.
module tb_roi_perf_monitor;

  localparam logic [31:0] SPC = 32'h00000170;
  localparam logic [31:0] EPC = 32'h00000264;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arm_m, arm_t, arm_s;
  logic [31:0] pc, ret;

  logic [1:0]  m_state, t_state, s_state;
  logic        m_busy, m_done, m_to, m_ovf;
  logic        t_busy, t_done, t_to, t_ovf;
  logic        s_busy, s_done, s_to, s_ovf;
  logic [31:0] m_cyc, m_ret, t_cyc, t_ret;
  logic [7:0]  s_cyc, s_ret;

  int checks = 0;
  int passed = 0;

  roi_perf_monitor u_main (
    .clk_i(clk), .rst_i(rst), .arm_i(arm_m), .pc_i(pc), .retire_cnt_i(ret),
    .state_o(m_state), .busy_o(m_busy), .done_o(m_done), .timeout_o(m_to),
    .ovf_o(m_ovf), .roi_cycles_o(m_cyc), .roi_retired_o(m_ret)
  );

  roi_perf_monitor #(.TIMEOUT(20)) u_to (
    .clk_i(clk), .rst_i(rst), .arm_i(arm_t), .pc_i(pc), .retire_cnt_i(ret),
    .state_o(t_state), .busy_o(t_busy), .done_o(t_done), .timeout_o(t_to),
    .ovf_o(t_ovf), .roi_cycles_o(t_cyc), .roi_retired_o(t_ret)
  );

  roi_perf_monitor #(.CNT_W(8), .TIMEOUT(0)) u_sat (
    .clk_i(clk), .rst_i(rst), .arm_i(arm_s), .pc_i(pc), .retire_cnt_i(ret),
    .state_o(s_state), .busy_o(s_busy), .done_o(s_done), .timeout_o(s_to),
    .ovf_o(s_ovf), .roi_cycles_o(s_cyc), .roi_retired_o(s_ret)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; arm_m = 1'b0; arm_t = 1'b0; arm_s = 1'b0; pc = '0; ret = '0;
    tick(2);
    check("rst_state", 32'(m_state), 0);
    check("rst_busy", 32'(m_busy), 0);
    check("rst_done", 32'(m_done), 0);
    check("rst_timeout", 32'(m_to), 0);
    check("rst_ovf", 32'(m_ovf), 0);
    check("rst_cycles", m_cyc, 0);
    check("rst_retired", m_ret, 0);
    rst = 1'b0;

    // Basic ROI
    arm_m = 1'b1; tick(); arm_m = 1'b0;
    check("basic_armed_state", 32'(m_state), 1);
    check("basic_armed_busy", 32'(m_busy), 1);
    pc = SPC; ret = 32'd100; tick();
    check("basic_active_state", 32'(m_state), 2);
    check("basic_active_cycles", m_cyc, 0);
    pc = 32'h0; tick(49);
    check("basic_still_active", 32'(m_state), 2);
    pc = EPC; ret = 32'd137; tick();
    check("basic_done_state", 32'(m_state), 3);
    check("basic_done", 32'(m_done), 1);
    check("basic_busy", 32'(m_busy), 0);
    check("basic_cycles", m_cyc, 50);
    check("basic_retired", m_ret, 37);
    check("basic_timeout", 32'(m_to), 0);
    check("basic_ovf", 32'(m_ovf), 0);
    pc = 32'h0; ret = 32'd999; tick(3);
    check("basic_hold_cycles", m_cyc, 50);
    check("basic_hold_retired", m_ret, 37);

    // Counter wrap
    arm_m = 1'b1; tick(); arm_m = 1'b0;
    pc = SPC; ret = 32'hFFFFFFF0; tick();
    pc = 32'h0; ret = 32'hFFFFFFFE; tick(9);
    pc = EPC; ret = 32'h00000005; tick();
    check("wrap_state", 32'(m_state), 3);
    check("wrap_cycles", m_cyc, 10);
    check("wrap_retired", m_ret, 21);

    // arm held high with START present: stays ARMED until arm drops
    arm_m = 1'b1; pc = SPC; tick(3);
    check("armheld_state", 32'(m_state), 1);
    check("armheld_cycles", m_cyc, 0);
    check("armheld_retired", m_ret, 0);
    arm_m = 1'b0; tick();
    check("armheld_active", 32'(m_state), 2);
    pc = 32'h0; tick(2);
    pc = EPC; ret = 32'd8; tick();
    check("armheld_cycles_end", m_cyc, 3);
    check("armheld_retired_end", m_ret, 3);

    // Timeout: TIMEOUT=20, START 5 cycles after arm, no END
    pc = 32'h0;
    arm_t = 1'b1; tick(); arm_t = 1'b0;
    tick(4);
    pc = SPC; ret = 32'd10; tick();
    check("to_active", 32'(t_state), 2);
    pc = 32'h0;
    for (int k = 1; k <= 14; k++) begin
      ret = 32'd10 + 32'(k); tick();
    end
    check("to_before_expiry", 32'(t_state), 2);
    ret = 32'd25; tick();
    check("to_state", 32'(t_state), 3);
    check("to_timeout", 32'(t_to), 1);
    check("to_cycles", t_cyc, 15);
    check("to_retired", t_ret, 15);
    pc = EPC; ret = 32'd40; tick();
    check("to_hold_cycles", t_cyc, 15);
    check("to_hold_timeout", 32'(t_to), 1);

    // Ordering: early END ignored, END coincides with watchdog expiry
    pc = 32'h0;
    arm_t = 1'b1; tick(); arm_t = 1'b0;
    tick();
    pc = EPC; tick();
    check("ord_early_end", 32'(t_state), 1);
    pc = 32'h0; tick();
    pc = SPC; ret = 32'd50; tick();
    check("ord_active", 32'(t_state), 2);
    pc = 32'h0; tick(15);
    pc = EPC; ret = 32'd80; tick();
    check("ord_state", 32'(t_state), 3);
    check("ord_timeout", 32'(t_to), 0);
    check("ord_cycles", t_cyc, 16);
    check("ord_retired", t_ret, 30);

    // Saturation with CNT_W=8
    pc = 32'h0;
    arm_s = 1'b1; tick(); arm_s = 1'b0;
    pc = SPC; ret = 32'd0; tick();
    pc = 32'h0;
    for (int k = 1; k <= 255; k++) begin
      ret = 32'(k); tick();
    end
    check("sat_edge_cycles", 32'(s_cyc), 255);
    check("sat_edge_retired", 32'(s_ret), 255);
    check("sat_edge_ovf", 32'(s_ovf), 0);
    ret = 32'd256; tick();
    check("sat_ovf", 32'(s_ovf), 1);
    check("sat_cycles_pinned", 32'(s_cyc), 255);
    for (int k = 257; k <= 299; k++) begin
      ret = 32'(k); tick();
    end
    pc = EPC; ret = 32'd300; tick();
    check("sat_state", 32'(s_state), 3);
    check("sat_cycles", 32'(s_cyc), 255);
    check("sat_retired", 32'(s_ret), 255);
    check("sat_ovf_sticky", 32'(s_ovf), 1);

    // Reset mid-ACTIVE, then re-arm mid-ACTIVE
    pc = 32'h0;
    arm_m = 1'b1; tick(); arm_m = 1'b0;
    pc = SPC; ret = 32'd500; tick();
    pc = 32'h0; ret = 32'd505; tick(3);
    rst = 1'b1; tick();
    check("midrst_state", 32'(m_state), 0);
    check("midrst_busy", 32'(m_busy), 0);
    check("midrst_cycles", m_cyc, 0);
    check("midrst_retired", m_ret, 0);
    rst = 1'b0;
    pc = SPC; tick();
    check("idle_ignores_start", 32'(m_state), 0);
    pc = 32'h0;
    arm_m = 1'b1; tick(); arm_m = 1'b0;
    pc = SPC; ret = 32'd1000; tick();
    pc = 32'h0; ret = 32'd1004; tick(5);
    arm_m = 1'b1; tick(); arm_m = 1'b0;
    check("rearm_state", 32'(m_state), 1);
    check("rearm_cycles", m_cyc, 0);
    check("rearm_retired", m_ret, 0);
    pc = SPC; ret = 32'd2000; tick();
    pc = 32'h0; ret = 32'd2003; tick(6);
    pc = EPC; ret = 32'd2010; tick();
    check("rearm_done", 32'(m_state), 3);
    check("rearm_final_cycles", m_cyc, 7);
    check("rearm_final_retired", m_ret, 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
